// File: rtl/live_trig_gen_if.sv
// Control and status bundle between the spill/trigger generator and its user.
// The generator sits on the slave side; the controller or bench uses master.
interface live_trig_gen_if;
  logic        enable;
  logic [31:0] live_len;
  logic [31:0] gap_len;
  logic [15:0] trig_period;
  logic        live;
  logic        trig;
  logic [31:0] trig_count;
  logic        spill_done;

  modport master (
    output enable, live_len, gap_len, trig_period,
    input  live, trig, trig_count, spill_done
  );

  modport slave (
    input  enable, live_len, gap_len, trig_period,
    output live, trig, trig_count, spill_done
  );
endinterface

// File: rtl/live_trig_gen.sv
// Spill generator: alternates live and gap windows while enabled and issues
// periodic trigger pulses inside each live window.
module live_trig_gen (
  input  logic             clk,
  input  logic             rst,
  live_trig_gen_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, LIVE, GAP} state_t;

  state_t      state_q, state_d;
  logic [31:0] live_len_q, live_len_d;
  logic [31:0] gap_len_q, gap_len_d;
  logic [15:0] period_q, period_d;
  logic [15:0] phase_q, phase_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic        done_q, done_d;
  logic        trig_w;
  logic        enter_live;

  // phase_q counts cycles since the last trigger; P=0 disables triggering.
  assign trig_w = (state_q == LIVE) && (period_q != 16'd0) &&
                  (phase_q == period_q - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      live_len_q <= 32'd1;
      gap_len_q  <= 32'd1;
      period_q   <= 16'd0;
      phase_q    <= 16'd0;
      cyc_q      <= 32'd0;
      tcnt_q     <= 32'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      live_len_q <= live_len_d;
      gap_len_q  <= gap_len_d;
      period_q   <= period_d;
      phase_q    <= phase_d;
      cyc_q      <= cyc_d;
      tcnt_q     <= tcnt_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    live_len_d = live_len_q;
    gap_len_d  = gap_len_q;
    period_d   = period_q;
    phase_d    = phase_q;
    cyc_d      = cyc_q;
    tcnt_d     = tcnt_q;
    done_d     = 1'b0;
    enter_live = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.enable) enter_live = 1'b1;
      end
      LIVE: begin
        cyc_d   = cyc_q + 32'd1;
        phase_d = trig_w ? 16'd0 : phase_q + 16'd1;
        if (trig_w && (tcnt_q != 32'hFFFF_FFFF)) tcnt_d = tcnt_q + 32'd1;
        // Lengths are stored already clamped to >=1, so len-1 never underflows.
        if (cyc_q == live_len_q - 32'd1) begin
          state_d = GAP;
          cyc_d   = 32'd0;
          done_d  = 1'b1;
        end
      end
      GAP: begin
        cyc_d = cyc_q + 32'd1;
        if (cyc_q == gap_len_q - 32'd1) begin
          if (bus.enable) enter_live = 1'b1;
          else begin
            state_d = IDLE;
            cyc_d   = 32'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (enter_live) begin
      state_d    = LIVE;
      live_len_d = (bus.live_len == 32'd0) ? 32'd1 : bus.live_len;
      gap_len_d  = (bus.gap_len == 32'd0) ? 32'd1 : bus.gap_len;
      period_d   = bus.trig_period;
      phase_d    = 16'd0;
      cyc_d      = 32'd0;
      tcnt_d     = 32'd0;
    end
  end

  assign bus.live       = (state_q == LIVE);
  assign bus.trig       = trig_w;
  assign bus.trig_count = tcnt_q;
  assign bus.spill_done = done_q;

endmodule

// File: tb/tb_live_trig_gen.sv
// Scoreboard bench for live_trig_gen: stimulus queues the expected outputs of
// each cycle, a negedge monitor pops and compares them against the DUT.
module tb_live_trig_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  live_trig_gen_if bus ();

  live_trig_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic        live;
    logic        trig;
    logic [31:0] cnt;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void push_exp(string tag, logic live, logic trig,
                                   logic [31:0] cnt, logic done);
    exp_t e;
    e.tag = tag; e.live = live; e.trig = trig; e.cnt = cnt; e.done = done;
    sb.push_back(e);
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the DUT presents live/trig/trig_count/spill_done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp({e.tag, ".live"},       {31'd0, bus.live},       {31'd0, e.live});
        cmp({e.tag, ".trig"},       {31'd0, bus.trig},       {31'd0, e.trig});
        cmp({e.tag, ".trig_count"}, bus.trig_count,          e.cnt);
        cmp({e.tag, ".spill_done"}, {31'd0, bus.spill_done}, {31'd0, e.done});
      end
    end
  end

  task automatic step_idle(string tag, logic [31:0] cnt);
    @(posedge clk); #1;
    push_exp(tag, 1'b0, 1'b0, cnt, 1'b0);
  endtask

  // One full live window plus its gap. L, P, G are the effective values the
  // DUT must use. At live cycle chg_k the inputs live_len/enable are rewritten;
  // enable takes value en_after at the start of the last gap cycle.
  task automatic run_window(string tag, int L, int P, int G, int chg_k,
                            logic [31:0] chg_len, logic chg_en, logic en_after);
    int fin;
    fin = (P != 0) ? L / P : 0;
    for (int k = 0; k < L; k++) begin
      @(posedge clk); #1;
      push_exp($sformatf("%s.k%0d", tag, k), 1'b1,
               (P != 0) && (((k + 1) % P) == 0),
               (P != 0) ? 32'(k / P) : 32'd0, 1'b0);
      if (k == chg_k) begin
        bus.live_len = chg_len;
        bus.enable   = chg_en;
      end
    end
    for (int g = 0; g < G; g++) begin
      @(posedge clk); #1;
      push_exp($sformatf("%s.g%0d", tag, g), 1'b0, 1'b0, 32'(fin), g == 0);
      if (g == G - 1) bus.enable = en_after;
    end
  endtask

  // n live cycles from k=0, then rst; expects an immediate clean IDLE.
  task automatic partial_live(string tag, int P, int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      push_exp($sformatf("%s.k%0d", tag, k), 1'b1,
               (P != 0) && (((k + 1) % P) == 0),
               (P != 0) ? 32'(k / P) : 32'd0, 1'b0);
    end
    rst = 1'b1;
    bus.enable = 1'b0;
    @(posedge clk); #1;
    push_exp({tag, ".rst"}, 1'b0, 1'b0, 32'd0, 1'b0);
    rst = 1'b0;
    step_idle({tag, ".idle0"}, 32'd0);
    step_idle({tag, ".idle1"}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b0;
    bus.live_len = 32'd0;
    bus.gap_len = 32'd0;
    bus.trig_period = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    push_exp("reset", 1'b0, 1'b0, 32'd0, 1'b0);
    step_idle("idle_a", 32'd0);
    step_idle("idle_b", 32'd0);

    // L=10 P=3 G=5 back to back; live_len changed to 3 mid-window.
    bus.live_len = 32'd10; bus.gap_len = 32'd5; bus.trig_period = 16'd3;
    bus.enable = 1'b1;
    run_window("w10p3a", 10, 3, 5, -1, 32'd0, 1'b1, 1'b1);
    run_window("w10p3b", 10, 3, 5, 4, 32'd3, 1'b1, 1'b1);
    run_window("w3p3",    3, 3, 5, -1, 32'd0, 1'b1, 1'b0);
    step_idle("idle_c", 32'd1);

    bus.live_len = 32'd4; bus.gap_len = 32'd2; bus.trig_period = 16'd1;
    bus.enable = 1'b1;
    run_window("w4p1", 4, 1, 2, -1, 32'd0, 1'b1, 1'b0);
    step_idle("idle_d", 32'd4);

    bus.trig_period = 16'd0; bus.enable = 1'b1;
    run_window("w4p0", 4, 0, 2, -1, 32'd0, 1'b1, 1'b0);
    step_idle("idle_e", 32'd0);

    bus.trig_period = 16'd5; bus.enable = 1'b1;
    run_window("w4p5", 4, 5, 2, -1, 32'd0, 1'b1, 1'b0);
    step_idle("idle_f", 32'd0);

    // Zero lengths behave as 1: alternating single live and gap cycles.
    bus.live_len = 32'd0; bus.gap_len = 32'd0; bus.trig_period = 16'd1;
    bus.enable = 1'b1;
    run_window("w0a", 1, 1, 1, -1, 32'd0, 1'b1, 1'b1);
    run_window("w0b", 1, 1, 1, -1, 32'd0, 1'b1, 1'b1);
    run_window("w0c", 1, 1, 1, -1, 32'd0, 1'b1, 1'b0);
    step_idle("idle_g", 32'd1);

    // enable dropped at k=2: window and gap complete, then IDLE.
    bus.live_len = 32'd10; bus.gap_len = 32'd3; bus.trig_period = 16'd4;
    bus.enable = 1'b1;
    run_window("drop", 10, 4, 3, 2, 32'd10, 1'b0, 1'b0);
    step_idle("idle_h0", 32'd2);
    step_idle("idle_h1", 32'd2);
    step_idle("idle_h2", 32'd2);

    // rst at k=5 of L=10 P=2.
    bus.live_len = 32'd10; bus.trig_period = 16'd2; bus.enable = 1'b1;
    partial_live("rstmid", 2, 6);

    // Maximum live_len must not end the window early.
    bus.live_len = 32'hFFFF_FFFF; bus.gap_len = 32'd1; bus.trig_period = 16'd7;
    bus.enable = 1'b1;
    partial_live("maxlen", 7, 20);

    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/live_trig_gen.md
LIVE_TRIG_GEN -- requirements
Module: live_trig_gen

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clk  input  1  system clock; all logic SHALL be on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 enable  input  1  run request; 1 = generate spills continuously.
REQ-005 live_len  input  32  live window length in cycles; 0 SHALL be treated as 1.
REQ-006 gap_len  input  32  off window length in cycles; 0 SHALL be treated as 1.
REQ-007 trig_period  input  16  cycles between triggers inside a live window; 0 = no triggers.
REQ-008 live  output  1  live/spill gate driven to the downstream input counter.
REQ-009 trig  output  1  single-cycle trigger pulse.
REQ-010 trig_count  output  32  triggers issued in the current or most recent live window.
REQ-011 spill_done  output  1  one-cycle pulse marking the end of a live window.

Function
REQ-012 The FSM SHALL have the states IDLE, LIVE and GAP; live SHALL be 1 only in LIVE.
REQ-013 IDLE: live=0 and trig=0; enable=1 SHALL move the FSM to LIVE on the next edge.
REQ-014 live_len, gap_len and trig_period SHALL be latched on every transition into LIVE; input changes mid-spill SHALL have no effect until the next spill.
REQ-015 LIVE SHALL last exactly L cycles, where L is the latched live_len (minimum 1); the live cycles are indexed k=0..L-1.
REQ-016 trig SHALL be 1 on live cycle k iff P!=0 and (k+1) mod P == 0, where P is the latched trig_period.
REQ-017 Each window SHALL therefore issue exactly floor(L/P) triggers, or 0 when P=0.
REQ-018 trig SHALL never be 1 while live=0.
REQ-019 trig_count SHALL be 0 in live cycle k=0.
REQ-020 trig_count SHALL increment by 1 in the cycle after each trig pulse.
REQ-021 trig_count SHALL saturate at 0xFFFFFFFF and SHALL NOT wrap.
REQ-022 After LIVE ends, trig_count SHALL hold its value until the next entry to LIVE.
REQ-023 spill_done SHALL be 1 for exactly one cycle: the first cycle after the last live cycle; trig_count SHALL equal the final window count in that cycle.
REQ-024 After LIVE the FSM SHALL enter GAP for exactly G cycles, where G is the latched gap_len (minimum 1).
REQ-025 At the end of GAP the FSM SHALL enter LIVE if enable=1, otherwise IDLE.
REQ-026 Deasserting enable during LIVE SHALL NOT truncate the window; the window SHALL complete and GAP SHALL run in full before the FSM returns to IDLE.
REQ-027 Length arithmetic SHALL use 32-bit counters; live_len=0xFFFFFFFF SHALL be supported without overflow.

Reset
REQ-028 rst=1 SHALL force state=IDLE, live=0, trig=0, trig_count=0 and spill_done=0 on the next edge.
REQ-029 rst SHALL take priority over all other inputs.
REQ-030 rst asserted mid-LIVE SHALL drop live with no spill_done pulse.
REQ-031 After rst is released, the block SHALL remain in IDLE until enable=1 is sampled.

Verification
REQ-032 L=10, P=3, G=5, enable held 1 -> live high for 10 cycles; trig on k=2,5,8; trig_count=3 with spill_done=1 in the next cycle; live low for 5 cycles, then high again with trig_count=0.
REQ-033 L=4, P=1 -> trig high on all 4 live cycles, trig_count=4 at spill_done. L=4, P=0 -> no trig and trig_count=0. L=4, P=5 -> no trig and trig_count=0.
REQ-034 live_len=0, gap_len=0 -> 1 live cycle and 1 gap cycle, alternating.
REQ-035 live_len changed from 10 to 3 at k=4 -> the current window still lasts 10 cycles; the next window lasts 3 cycles.
REQ-036 enable dropped at k=2 of L=10 -> window completes all 10 cycles, spill_done pulses, G gap cycles follow, FSM returns to IDLE, live stays 0.
REQ-037 rst at k=5 of L=10, P=2 -> next cycle live=0, trig=0, trig_count=0, no spill_done pulse; FSM in IDLE.
